// File: rtl/ysyx_core_ctrl_if.sv
// Handshake and decode-flag bundle between the NPC sequencer and its IFU/LSU/datapath.
// master = sequencer side, slave = datapath/memory side.
interface ysyx_core_ctrl_if;
    logic ifu_req_valid;
    logic ifu_req_ready;
    logic ifu_resp_valid;
    logic inst_latch_en;
    logic dec_rf_wr_en;
    logic dec_do_jump;
    logic dec_is_load;
    logic dec_is_store;
    logic dec_is_ebreak;
    logic lsu_req_valid;
    logic lsu_req_ready;
    logic lsu_resp_valid;
    logic rf_wr_commit;
    logic pc_update;
    logic pc_jump_sel;

    modport master (
        output ifu_req_valid, inst_latch_en, lsu_req_valid,
               rf_wr_commit, pc_update, pc_jump_sel,
        input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
               dec_rf_wr_en, dec_do_jump, dec_is_load, dec_is_store, dec_is_ebreak
    );

    modport slave (
        input  ifu_req_valid, inst_latch_en, lsu_req_valid,
               rf_wr_commit, pc_update, pc_jump_sel,
        output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
               dec_rf_wr_en, dec_do_jump, dec_is_load, dec_is_store, dec_is_ebreak
    );
endinterface

// File: rtl/ysyx_core_ctrl.sv
// Multi-cycle instruction sequencer for the single-issue NPC core.
// Strobes are decoded from state and decode flags; only state, timer, sticky flags and instret are registered.
module ysyx_core_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    ysyx_core_ctrl_if.master bus,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    // state        | meaning
    // S_IDLE       | post-reset, one cycle before the first fetch
    // S_FETCH      | ifu request valid, waiting for ready
    // S_FETCH_WAIT | waiting for instruction word (timed)
    // S_DECODE     | decode flags valid, choose path
    // S_MEM        | lsu request valid, waiting for ready
    // S_MEM_WAIT   | waiting for load data / store ack (timed)
    // S_WB         | commit rd, update pc, retire
    // S_STOP       | halted (ebreak) or error (timeout); sticky until rst
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_DECODE     = 3'd3,
        S_MEM        = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WB         = 3'd6,
        S_STOP       = 3'd7
    } state_e;

    localparam int            TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             expired;

    // Down-counter loaded with TIMEOUT-1 on wait entry; zero means the last permitted wait cycle.
    assign expired = (wait_q == '0);

    always_comb begin
        state_d           = state_q;
        wait_d            = wait_q;
        halted_d          = halted_q;
        err_d             = err_q;
        instret_d         = instret_q;
        bus.ifu_req_valid = 1'b0;
        bus.inst_latch_en = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.rf_wr_commit  = 1'b0;
        bus.pc_update     = 1'b0;
        bus.pc_jump_sel   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.ifu_req_valid = 1'b1;
                if (bus.ifu_req_ready) begin
                    state_d = S_FETCH_WAIT;
                    wait_d  = WAIT_LOAD;
                end
            end
            S_FETCH_WAIT: begin
                if (bus.ifu_resp_valid) begin
                    bus.inst_latch_en = 1'b1;
                    state_d           = S_DECODE;
                end else if (expired) begin
                    state_d = S_STOP;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_DECODE: begin
                if (bus.dec_is_ebreak) begin
                    state_d   = S_STOP;
                    halted_d  = 1'b1;
                    instret_d = instret_q + 1'b1;
                end else if (bus.dec_is_load || bus.dec_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.lsu_req_valid = 1'b1;
                if (bus.lsu_req_ready) begin
                    state_d = S_MEM_WAIT;
                    wait_d  = WAIT_LOAD;
                end
            end
            S_MEM_WAIT: begin
                if (bus.lsu_resp_valid) begin
                    state_d = S_WB;
                end else if (expired) begin
                    state_d = S_STOP;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_WB: begin
                // load+store together behaves as a store: no rd write
                bus.rf_wr_commit = bus.dec_rf_wr_en & ~bus.dec_is_store;
                bus.pc_update    = 1'b1;
                bus.pc_jump_sel  = bus.dec_do_jump;
                instret_d        = instret_q + 1'b1;
                state_d          = S_FETCH;
            end
            S_STOP: state_d = S_STOP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    assign halted  = halted_q;
    assign err     = err_q;
    assign state_o = state_q;
    assign instret = instret_q;

endmodule
